// File: rtl/i2c_phase_gen.sv
// rtl/i2c_phase_gen.sv - four-phase SCL timebase with per-phase strobes, clock stretch and period-aligned divider reload
module i2c_phase_gen #(
    parameter int CNT_W   = 16,
    parameter int MIN_DIV = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic [CNT_W-1:0] div_cnt,
    input  logic             scl_in,
    output logic [1:0]       phase,
    output logic [3:0]       tick,
    output logic             scl_o,
    output logic             busy,
    output logic             stretching,
    output logic             div_err
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_STRETCH
    } state_t;

    localparam logic [CNT_W-1:0] MIN_Q = CNT_W'(MIN_DIV);

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [CNT_W-1:0] div_q, div_q_n;
    logic [1:0]       phase_n;
    logic [3:0]       tick_n;
    logic             div_err_n;

    logic             div_low;
    logic [CNT_W-1:0] div_sat;
    logic             hold;
    logic             quarter_end;

    assign div_low     = (div_cnt < MIN_Q);
    assign div_sat     = div_low ? MIN_Q : div_cnt;
    // A slave holding SCL low only matters while SCL is meant to be high and rising
    assign hold        = (phase == 2'd2) && !scl_in;
    assign quarter_end = (cnt == div_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            div_q   <= MIN_Q;
            phase   <= 2'd0;
            tick    <= 4'd0;
            div_err <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            div_q   <= div_q_n;
            phase   <= phase_n;
            tick    <= tick_n;
            div_err <= div_err_n;
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        div_q_n   = div_q;
        phase_n   = phase;
        tick_n    = 4'd0;
        div_err_n = div_err;
        case (state)
            ST_IDLE: begin
                if (enable) begin
                    state_n   = ST_RUN;
                    cnt_n     = '0;
                    phase_n   = 2'd0;
                    tick_n    = 4'b0001;
                    div_q_n   = div_sat;
                    div_err_n = div_low;
                end
            end
            ST_RUN, ST_STRETCH: begin
                if (hold) begin
                    state_n = ST_STRETCH;
                end else begin
                    state_n = ST_RUN;
                    if (!quarter_end) begin
                        cnt_n = cnt + 1'b1;
                    end else begin
                        cnt_n   = '0;
                        phase_n = phase + 2'd1;
                        if (phase == 2'd3) begin
                            // Period boundary: the only point where the divider reloads or the run stops
                            if (enable) begin
                                tick_n    = 4'b0001;
                                div_q_n   = div_sat;
                                div_err_n = div_err | div_low;
                            end else begin
                                state_n = ST_IDLE;
                            end
                        end else begin
                            tick_n = 4'b0001 << phase_n;
                        end
                    end
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    assign scl_o      = (state == ST_IDLE) | phase[1];
    assign busy       = (state != ST_IDLE);
    assign stretching = (state == ST_STRETCH);

endmodule

// File: tb/tb_i2c_phase_gen.sv
// tb/tb_i2c_phase_gen.sv - self-checking bench for i2c_phase_gen against a period-position model
module tb_i2c_phase_gen;

    localparam int MIN = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic        scl_in = 1'b1;
    logic [15:0] div_cnt = 16'd4;
    logic [1:0]  phase;
    logic [3:0]  tick;
    logic        scl_o, busy, stretching, div_err;

    int checks = 0;
    int errors = 0;

    // Model: position within the unstretched period plus the latched quarter length
    bit m_busy = 0, m_stretch = 0, m_fresh = 0, m_err = 0;
    int m_e = 0, m_dq = MIN;

    i2c_phase_gen #(.CNT_W(16), .MIN_DIV(MIN)) dut (
        .clk(clk), .rst(rst), .enable(enable), .div_cnt(div_cnt), .scl_in(scl_in),
        .phase(phase), .tick(tick), .scl_o(scl_o), .busy(busy),
        .stretching(stretching), .div_err(div_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    task automatic latch_div(input bit fresh_run);
        int d;
        d = int'(div_cnt);
        m_dq = (d < MIN) ? MIN : d;
        m_err = (fresh_run ? 1'b0 : m_err) | (d < MIN);
    endtask

    task automatic model_step();
        int q;
        q = m_dq + 1;
        if (rst) begin
            m_busy = 0; m_e = 0; m_stretch = 0; m_fresh = 0; m_err = 0;
        end else if (!m_busy) begin
            m_fresh = 0;
            if (enable) begin
                latch_div(1);
                m_busy = 1; m_e = 0; m_fresh = 1; m_stretch = 0;
            end
        end else if ((m_e / q) == 2 && !scl_in) begin
            m_stretch = 1; m_fresh = 0;
        end else begin
            m_stretch = 0;
            m_e++;
            if (m_e == 4 * q) begin
                m_e = 0;
                if (enable) begin
                    latch_div(0);
                    m_fresh = 1;
                end else begin
                    m_busy = 0; m_fresh = 0;
                end
            end else begin
                m_fresh = ((m_e % q) == 0);
            end
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        begin
            int q, ph;
            q = m_dq + 1;
            ph = m_busy ? (m_e / q) : 0;
            chk("model_phase", phase, ph);
            chk("model_tick", tick, (m_busy && m_fresh) ? (1 << ph) : 0);
            chk("model_scl_o", scl_o, m_busy ? (ph >= 2) : 1);
            chk("model_busy", busy, m_busy);
            chk("model_stretching", stretching, m_stretch);
            chk("model_div_err", div_err, m_err);
        end
    end

    task automatic win(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic chk_reset_vals(input string nm);
        chk({nm, "_phase"}, phase, 0);
        chk({nm, "_tick"}, tick, 0);
        chk({nm, "_scl_o"}, scl_o, 1);
        chk({nm, "_busy"}, busy, 0);
        chk({nm, "_stretching"}, stretching, 0);
        chk({nm, "_div_err"}, div_err, 0);
    endtask

    task automatic restart(input logic [15:0] d);
        rst = 1'b1; scl_in = 1'b1;
        win(1);
        rst = 1'b0; div_cnt = d; enable = 1'b1;
        win(1);
    endtask

    initial begin
        int st, p2, t3k, t2x, exp_t;

        // Basic period with div_cnt=4
        win(1);
        chk_reset_vals("reset");
        rst = 1'b0; enable = 1'b1;
        for (int k = 1; k <= 21; k++) begin
            win(1);
            exp_t = (k == 1 || k == 21) ? 1 : (k == 6) ? 2 : (k == 11) ? 4 : (k == 16) ? 8 : 0;
            chk("t1_tick", tick, exp_t);
            chk("t1_scl_o", scl_o, (k >= 11 && k <= 20));
        end

        // Clamped divider, enable dropped in phase 0, then clean re-enable
        restart(16'd1);
        chk("t2_err_set", div_err, 1);
        chk("t2_tick0", tick, 1);
        enable = 1'b0;
        win(4);
        chk("t2_tick1_q4", tick, 2);
        win(11);
        chk("t2_busy_ph3", busy, 1);
        chk("t2_phase3", phase, 3);
        win(1);
        chk("t2_idle_busy", busy, 0);
        chk("t2_idle_scl", scl_o, 1);
        chk("t2_idle_tick", tick, 0);
        div_cnt = 16'd5; enable = 1'b1;
        win(1);
        chk("t2_err_clr", div_err, 0);
        chk("t2_tick0_b", tick, 1);
        win(6);
        chk("t2_tick1_q6", tick, 2);

        // Divider change mid-period takes effect at the next boundary
        restart(16'd4);
        win(6);
        chk("t3_phase1", phase, 1);
        div_cnt = 16'd9;
        win(14);
        chk("t3_tick0_k21", tick, 1);
        win(10);
        chk("t3_tick1_k31", tick, 2);
        win(30);
        chk("t3_tick0_k61", tick, 1);

        // Seven-cycle stretch from phase-2 entry
        restart(16'd4);
        win(10);
        chk("t4_tick2", tick, 4);
        scl_in = 1'b0;
        st = 0; p2 = 1; t3k = 0; t2x = 0;
        for (int k = 12; k <= 30; k++) begin
            win(1);
            if (stretching) st++;
            if (phase == 2'd2) p2++;
            if (tick == 4'd8 && t3k == 0) t3k = k;
            if (tick == 4'd4) t2x++;
            if (k == 18) scl_in = 1'b1;
        end
        chk("t4_stretch_cycles", st, 7);
        chk("t4_phase2_len", p2, 12);
        chk("t4_tick3_cycle", t3k, 23);
        chk("t4_extra_tick2", t2x, 0);

        // Reset mid phase 2
        restart(16'd4);
        win(12);
        chk("t6_phase2", phase, 2);
        rst = 1'b1;
        win(1);
        chk_reset_vals("t6_rst");
        rst = 1'b0;
        win(1);
        chk("t6_restart_tick", tick, 1);
        chk("t6_restart_busy", busy, 1);
        chk("t6_restart_scl", scl_o, 0);

        // Randomized traffic, checked by the model each cycle
        for (int i = 0; i < 4000; i++) begin
            win(1);
            rst = ($urandom_range(199) == 0);
            if ($urandom_range(39) == 0) enable = ~enable;
            if ($urandom_range(9) == 0) div_cnt = 16'($urandom_range(7));
            if (scl_in) scl_in = ($urandom_range(5) != 0);
            else        scl_in = ($urandom_range(2) == 0);
        end

        win(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
